execute_cp: RTL and testbench

- Execute-stage control path, directly downstream of the decode-stage control register.
- Consumes the registered decode control bundle and the ALU flags.
- Resolves branches and jumps, drives the PC-select and front-end flush, and registers the surviving control bits into the EX/MEM control register.
- Keeps branch statistics counters for performance inspection.

---
 rtl/execute_cp.sv | 92 +++++++++
 tb/tb_execute_cp.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/execute_cp.sv
// Execute-stage control path: resolves branches and jumps, drives the PC select and
// front-end flush, registers the surviving control bits into EX/MEM, and counts branches.
module execute_cp #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             stall_ex_i,
    input  logic             flush_ex_i,
    input  logic             branch_ex_i,
    input  logic             jump_ex_i,
    input  logic [2:0]       funct3_ex_i,
    input  logic             mem_write_ex_i,
    input  logic             reg_write_ex_i,
    input  logic [1:0]       result_src_ex_i,
    input  logic [1:0]       data_memory_size_ex_i,
    input  logic             data_memory_sign_ex_i,
    input  logic             zero_ex_i,
    input  logic             lt_ex_i,
    input  logic             ltu_ex_i,
    output logic             pc_src_ex_o,
    output logic             flush_fd_o,
    output logic             mem_read_ex_o,
    output logic             mem_write_mem_o,
    output logic             reg_write_mem_o,
    output logic [1:0]       result_src_mem_o,
    output logic [1:0]       data_memory_size_mem_o,
    output logic             data_memory_sign_mem_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
);

    logic cond;
    logic active;

    always_comb begin
        cond = 1'b0;
        unique case (funct3_ex_i)
            3'b000:  cond = zero_ex_i;
            3'b001:  cond = !zero_ex_i;
            3'b100:  cond = lt_ex_i;
            3'b101:  cond = !lt_ex_i;
            3'b110:  cond = ltu_ex_i;
            3'b111:  cond = !ltu_ex_i;
            default: cond = 1'b0;
        endcase
    end

    // A stalled or killed instruction must neither redirect fetch nor be counted.
    assign active        = !flush_ex_i && !stall_ex_i;
    assign pc_src_ex_o   = active && (jump_ex_i || (branch_ex_i && cond));
    assign flush_fd_o    = pc_src_ex_o;
    assign mem_read_ex_o = (result_src_ex_i == 2'b01) && !flush_ex_i;

    // Flush takes priority over stall so a killed instruction leaves a bubble behind.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_write_mem_o        <= 1'b0;
            reg_write_mem_o        <= 1'b0;
            result_src_mem_o       <= 2'b00;
            data_memory_size_mem_o <= 2'b00;
            data_memory_sign_mem_o <= 1'b0;
        end else if (flush_ex_i) begin
            mem_write_mem_o        <= 1'b0;
            reg_write_mem_o        <= 1'b0;
            result_src_mem_o       <= 2'b00;
            data_memory_size_mem_o <= 2'b00;
            data_memory_sign_mem_o <= 1'b0;
        end else if (!stall_ex_i) begin
            mem_write_mem_o        <= mem_write_ex_i;
            reg_write_mem_o        <= reg_write_ex_i;
            result_src_mem_o       <= result_src_ex_i;
            data_memory_size_mem_o <= data_memory_size_ex_i;
            data_memory_sign_mem_o <= data_memory_sign_ex_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            branch_cnt_o <= '0;
            taken_cnt_o  <= '0;
        end else if (active) begin
            if (branch_ex_i) begin
                branch_cnt_o <= branch_cnt_o + 1'b1;
            end
            if (pc_src_ex_o) begin
                taken_cnt_o <= taken_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_execute_cp.sv
// Self-checking bench for execute_cp: a reference model pushes expected EX/MEM and counter
// values into a queue at drive time; they are popped and compared after the clock edge.
module tb_execute_cp;

    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             stall_ex_i = 1'b0, flush_ex_i = 1'b0;
    logic             branch_ex_i = 1'b0, jump_ex_i = 1'b0;
    logic [2:0]       funct3_ex_i = 3'b000;
    logic             mem_write_ex_i = 1'b0, reg_write_ex_i = 1'b0;
    logic [1:0]       result_src_ex_i = 2'b00, data_memory_size_ex_i = 2'b00;
    logic             data_memory_sign_ex_i = 1'b0;
    logic             zero_ex_i = 1'b0, lt_ex_i = 1'b0, ltu_ex_i = 1'b0;
    logic             pc_src_ex_o, flush_fd_o, mem_read_ex_o;
    logic             mem_write_mem_o, reg_write_mem_o, data_memory_sign_mem_o;
    logic [1:0]       result_src_mem_o, data_memory_size_mem_o;
    logic [CNT_W-1:0] branch_cnt_o, taken_cnt_o;

    execute_cp #(.CNT_W(CNT_W)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .stall_ex_i             (stall_ex_i),
        .flush_ex_i             (flush_ex_i),
        .branch_ex_i            (branch_ex_i),
        .jump_ex_i              (jump_ex_i),
        .funct3_ex_i            (funct3_ex_i),
        .mem_write_ex_i         (mem_write_ex_i),
        .reg_write_ex_i         (reg_write_ex_i),
        .result_src_ex_i        (result_src_ex_i),
        .data_memory_size_ex_i  (data_memory_size_ex_i),
        .data_memory_sign_ex_i  (data_memory_sign_ex_i),
        .zero_ex_i              (zero_ex_i),
        .lt_ex_i                (lt_ex_i),
        .ltu_ex_i               (ltu_ex_i),
        .pc_src_ex_o            (pc_src_ex_o),
        .flush_fd_o             (flush_fd_o),
        .mem_read_ex_o          (mem_read_ex_o),
        .mem_write_mem_o        (mem_write_mem_o),
        .reg_write_mem_o        (reg_write_mem_o),
        .result_src_mem_o       (result_src_mem_o),
        .data_memory_size_mem_o (data_memory_size_mem_o),
        .data_memory_sign_mem_o (data_memory_sign_mem_o),
        .branch_cnt_o           (branch_cnt_o),
        .taken_cnt_o            (taken_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic             mw;
        logic             rw;
        logic [1:0]       rs;
        logic [1:0]       sz;
        logic             sg;
        logic [CNT_W-1:0] bc;
        logic [CNT_W-1:0] tc;
    } exp_t;

    exp_t exp_q[$];
    exp_t model;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    function automatic logic ref_cond(input logic [2:0] f3, input logic z, input logic l,
                                      input logic lu);
        case (f3)
            3'b000:  return z;
            3'b001:  return !z;
            3'b100:  return l;
            3'b101:  return !l;
            3'b110:  return lu;
            3'b111:  return !lu;
            default: return 1'b0;
        endcase
    endfunction

    // Drive one instruction, check combinational outputs, push expected state, then
    // pop and compare after the clock edge. Returns the observed pc_src.
    task automatic step(input logic br, input logic jp, input logic [2:0] f3,
                        input logic mw, input logic rw, input logic [1:0] rs,
                        input logic [1:0] sz, input logic sg, input logic z,
                        input logic l, input logic lu, input logic st, input logic fl,
                        output logic pc_seen);
        logic act, pc;
        exp_t e;
        branch_ex_i = br; jump_ex_i = jp; funct3_ex_i = f3;
        mem_write_ex_i = mw; reg_write_ex_i = rw; result_src_ex_i = rs;
        data_memory_size_ex_i = sz; data_memory_sign_ex_i = sg;
        zero_ex_i = z; lt_ex_i = l; ltu_ex_i = lu; stall_ex_i = st; flush_ex_i = fl;
        #1;
        act = !fl && !st;
        pc  = act && (jp || (br && ref_cond(f3, z, l, lu)));
        pc_seen = pc_src_ex_o;
        chk("pc_src", pc_src_ex_o, pc);
        chk("flush_fd", flush_fd_o, pc);
        chk("mem_read", mem_read_ex_o, (rs == 2'b01) && !fl);
        e = model;
        if (fl) begin
            e.mw = 0; e.rw = 0; e.rs = 0; e.sz = 0; e.sg = 0;
        end else if (!st) begin
            e.mw = mw; e.rw = rw; e.rs = rs; e.sz = sz; e.sg = sg;
        end
        if (act) begin
            e.bc = e.bc + CNT_W'(br);
            e.tc = e.tc + CNT_W'(pc);
        end
        model = e;
        exp_q.push_back(e);
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0) begin
            chk("queue_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            chk("mem_write_mem", mem_write_mem_o, e.mw);
            chk("reg_write_mem", reg_write_mem_o, e.rw);
            chk("result_src_mem", result_src_mem_o, e.rs);
            chk("size_mem", data_memory_size_mem_o, e.sz);
            chk("sign_mem", data_memory_sign_mem_o, e.sg);
            chk("branch_cnt", branch_cnt_o, e.bc);
            chk("taken_cnt", taken_cnt_o, e.tc);
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_mw"}, mem_write_mem_o, 0);
        chk({tag, "_rw"}, reg_write_mem_o, 0);
        chk({tag, "_rs"}, result_src_mem_o, 0);
        chk({tag, "_sz"}, data_memory_size_mem_o, 0);
        chk({tag, "_sg"}, data_memory_sign_mem_o, 0);
        chk({tag, "_bc"}, branch_cnt_o, 0);
        chk({tag, "_tc"}, taken_cnt_o, 0);
    endtask

    task automatic mid_reset();
        rst_ni = 1'b0;
        #1;
        check_reset_state("rst_mid");
        model = '0;
        #1;
        rst_ni = 1'b1;
    endtask

    logic [2:0] f3_tbl [7] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
    logic       pc_tbl [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       pcs;

    initial begin
        model = '0;
        #1;
        check_reset_state("rst_init");
        #12;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Load reg_write, then reset mid-cycle and verify the first clock after release loads.
        step(0, 0, 3'b000, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, pcs);
        chk("pre_rst_rw", reg_write_mem_o, 1);
        mid_reset();
        step(0, 0, 3'b000, 0, 1, 2'b01, 2'b11, 1, 0, 0, 0, 0, 0, pcs);
        chk("post_rst_load", reg_write_mem_o, 1);

        // Branch decode table with (zero, lt, ltu) = (1, 0, 1).
        for (int i = 0; i < 7; i++) begin
            step(1, 0, f3_tbl[i], 0, 0, 2'b00, 2'b00, 0, 1, 0, 1, 0, 0, pcs);
            chk($sformatf("br_tbl%0d", i), pcs, pc_tbl[i]);
        end
        chk("br_cnt7", branch_cnt_o, 7);
        chk("tk_cnt3", taken_cnt_o, 3);

        // Jump, then jump killed by flush.
        step(0, 1, 3'b000, 0, 1, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, pcs);
        chk("jump_pc", pcs, 1);
        step(0, 1, 3'b000, 1, 1, 2'b01, 2'b10, 1, 0, 0, 0, 0, 1, pcs);
        chk("jump_flush_pc", pcs, 0);
        chk("flush_bubble_rw", reg_write_mem_o, 0);
        chk("flush_tk_hold", taken_cnt_o, 4);

        // Stall holds EX/MEM; a stalled taken branch counts once when released.
        step(0, 0, 3'b000, 0, 1, 2'b01, 2'b10, 0, 0, 0, 0, 0, 0, pcs);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 3'b000, 1, 0, 2'b10, 2'b01, 1, 1, 0, 0, 1, 0, pcs);
            chk("stall_rs_hold", result_src_mem_o, 2'b01);
        end
        step(1, 0, 3'b000, 1, 0, 2'b10, 2'b01, 1, 1, 0, 0, 0, 0, pcs);
        chk("stall_br_once", branch_cnt_o, 8);

        // Stall and flush together: bubble wins.
        step(0, 0, 3'b000, 1, 1, 2'b11, 2'b11, 1, 0, 0, 0, 1, 1, pcs);
        chk("stall_flush_mw", mem_write_mem_o, 0);

        // Randomised traffic against the model.
        for (int i = 0; i < 40; i++) begin
            step(1'($urandom), 1'($urandom_range(0, 3) == 0), 3'($urandom),
                 1'($urandom), 1'($urandom), 2'($urandom), 2'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 5) == 0), pcs);
        end

        // Counter wrap: 17 jumps from a cleared counter on a 4-bit counter.
        @(negedge clk_i);
        mid_reset();
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 3'b000, 0, 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 0, pcs);
        end
        chk("wrap_tk", taken_cnt_o, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
